// File: rtl/audio_route_matrix.sv
// Registered audio routing matrix: every destination picks one source stream and
// crossfades through silence (fade-out, switch, fade-in) whenever its selection changes.

module audio_route_lane #(
  parameter int NUM_SRC   = 6,
  parameter int WIDTH     = 16,
  parameter int RAMP_LOG2 = 5,
  parameter int SEL_W     = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC-1:0][WIDTH-1:0]   src_sample,
  input  logic [NUM_SRC-1:0]              src_valid,
  input  logic [SEL_W-1:0]                sel,
  output logic [WIDTH-1:0]                sample,
  output logic                            valid,
  output logic                            busy
);
  localparam int GW = RAMP_LOG2 + 1;
  localparam int PW = WIDTH + RAMP_LOG2 + 1;
  localparam logic [GW-1:0]    FULL   = {1'b1, {RAMP_LOG2{1'b0}}};
  localparam logic [SEL_W-1:0] SILENT = SEL_W'(NUM_SRC);

  localparam logic [1:0] ACTIVE   = 2'd0;
  localparam logic [1:0] FADE_OUT = 2'd1;
  localparam logic [1:0] FADE_IN  = 2'd2;

  logic [1:0]       state, state_nx;
  logic [GW-1:0]    gain, gain_step, gain_nx;
  logic [SEL_W-1:0] cur_sel, sel_nx;
  logic             strobe, go_silent;
  logic [WIDTH-1:0] pick;
  logic signed [PW-1:0] a, b, prod, scaled;

  // Silent codes never match a source index, so they never strobe.
  always_comb begin
    strobe = 1'b0;
    pick   = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (cur_sel == SEL_W'(s)) begin
        strobe = src_valid[s];
        pick   = src_sample[s];
      end
    end
  end

  always_comb begin
    a      = {{(PW-WIDTH){pick[WIDTH-1]}}, pick};
    b      = {{(PW-GW){1'b0}}, gain};
    prod   = a * b;
    scaled = prod >>> RAMP_LOG2;
  end

  always_comb begin
    gain_step = gain;
    if (strobe && state == FADE_OUT && gain != '0)  gain_step = gain - GW'(1);
    if (strobe && state == FADE_IN  && gain != FULL) gain_step = gain + GW'(1);

    state_nx  = state;
    gain_nx   = gain_step;
    sel_nx    = cur_sel;
    go_silent = 1'b0;
    case (state)
      ACTIVE: begin
        if (sel != cur_sel) begin
          if (cur_sel >= SILENT) begin
            // Nothing audible to fade out: jump straight to the new source.
            sel_nx = sel;
            if (sel < SILENT) begin
              state_nx = FADE_IN;
              gain_nx  = '0;
            end
          end else begin
            state_nx = FADE_OUT;
          end
        end
      end
      FADE_OUT: begin
        if (gain_step == '0) begin
          sel_nx = sel;
          if (sel < SILENT) begin
            state_nx = FADE_IN;
          end else begin
            state_nx  = ACTIVE;
            gain_nx   = FULL;
            go_silent = 1'b1;
          end
        end else if (sel == cur_sel) begin
          state_nx = FADE_IN;
        end
      end
      FADE_IN: begin
        if (sel != cur_sel)       state_nx = FADE_OUT;
        else if (gain_step == FULL) state_nx = ACTIVE;
      end
      default: state_nx = ACTIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACTIVE;
      gain    <= FULL;
      cur_sel <= sel;
      sample  <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      gain    <= gain_nx;
      cur_sel <= sel_nx;
      busy    <= (state_nx != ACTIVE);
      if (go_silent) begin
        sample <= '0;
        valid  <= 1'b0;
      end else begin
        valid <= strobe;
        if (strobe) sample <= scaled[WIDTH-1:0];
      end
    end
  end
endmodule

module audio_route_matrix #(
  parameter int NUM_SRC   = 6,
  parameter int NUM_DST   = 6,
  parameter int WIDTH     = 16,
  parameter int RAMP_LOG2 = 5,
  parameter int SEL_W     = $clog2(NUM_SRC + 1)
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic [NUM_SRC-1:0][WIDTH-1:0]   sample_in,
  input  logic [NUM_SRC-1:0]              valid_in,
  input  logic [NUM_DST-1:0][SEL_W-1:0]   sel_in,
  output logic [NUM_DST-1:0][WIDTH-1:0]   sample_out,
  output logic [NUM_DST-1:0]              valid_out,
  output logic [NUM_DST-1:0]              busy_out
);
  for (genvar d = 0; d < NUM_DST; d++) begin : g_dst
    audio_route_lane #(
      .NUM_SRC(NUM_SRC), .WIDTH(WIDTH), .RAMP_LOG2(RAMP_LOG2), .SEL_W(SEL_W)
    ) u_lane (
      .clk        (clk_in),
      .rst        (rst_in),
      .src_sample (sample_in),
      .src_valid  (valid_in),
      .sel        (sel_in[d]),
      .sample     (sample_out[d]),
      .valid      (valid_out[d]),
      .busy       (busy_out[d])
    );
  end
endmodule
